// File: rtl/block_average_ctrl_if.sv
// block_average_ctrl_if: sample path, configuration and status signals of the block averager
interface block_average_ctrl_if #(
    parameter int DATA_W  = 8,
    parameter int PHASE_W = 32
);
    logic [PHASE_W-1:0]       phase;
    logic signed [DATA_W-1:0] signal;
    logic                     cfg_load;
    logic [4:0]               tap_sel;
    logic [2:0]               log_len;
    logic signed [DATA_W-1:0] filtered;
    logic                     valid;
    logic                     primed;
    logic                     busy;
    logic                     overrun;

    modport master (
        output phase, signal, cfg_load, tap_sel, log_len,
        input  filtered, valid, primed, busy, overrun
    );

    modport slave (
        input  phase, signal, cfg_load, tap_sel, log_len,
        output filtered, valid, primed, busy, overrun
    );
endinterface

// File: rtl/block_average_ctrl.sv
// block_average_ctrl: NCO-strobed sliding-window averager using a circular buffer and running sum
module block_average_ctrl #(
    parameter int DATA_W      = 8,
    parameter int MAX_LOG_LEN = 6,
    parameter int PHASE_W     = 32
) (
    input logic clk,
    input logic rst,
    block_average_ctrl_if.slave io
);
    localparam int SW = DATA_W + MAX_LOG_LEN;
    localparam int AW = MAX_LOG_LEN;

    typedef enum logic [2:0] {FLUSH, IDLE, READ, UPDATE, OUTPUT} state_t;

    state_t                   state;
    logic [4:0]               tap_q;
    logic [2:0]               len_q;
    logic                     prev_bit;
    logic                     strobe;
    logic [PHASE_W-1:0]       ph;
    logic signed [DATA_W-1:0] sample;
    logic signed [DATA_W-1:0] oldest;
    logic signed [SW-1:0]     sum;
    logic [AW-1:0]            wr_ptr;
    logic [AW-1:0]            faddr;
    logic [AW:0]              cnt;
    logic [AW:0]              win;
    logic signed [DATA_W-1:0] mem [2**AW];
    logic                     mem_we;
    logic [AW-1:0]            mem_wa;
    logic signed [DATA_W-1:0] mem_wd;

    assign ph     = io.phase;
    assign strobe = ph[tap_q] ^ prev_bit;
    assign win    = (AW+1)'(1) << len_q;
    assign mem_we = !io.cfg_load && (state == FLUSH || state == UPDATE);
    assign mem_wa = state == FLUSH ? faddr : wr_ptr;
    assign mem_wd = state == FLUSH ? '0 : sample;

    always_ff @(posedge clk)
        if (mem_we) mem[mem_wa] <= mem_wd;

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= FLUSH;
            tap_q       <= 5'd27;
            len_q       <= 3'(MAX_LOG_LEN);
            prev_bit    <= 1'b0;
            faddr       <= '0;
            sum         <= '0;
            wr_ptr      <= '0;
            cnt         <= '0;
            sample      <= '0;
            oldest      <= '0;
            io.filtered <= '0;
            io.valid    <= 1'b0;
            io.primed   <= 1'b0;
            io.busy     <= 1'b1;
            io.overrun  <= 1'b0;
        end else begin
            prev_bit <= ph[tap_q];
            io.valid <= 1'b0;
            if (io.cfg_load) begin
                // reconfiguration abandons any in-flight update and restarts the flush
                tap_q      <= io.tap_sel;
                len_q      <= (io.log_len > 3'(MAX_LOG_LEN)) ? 3'(MAX_LOG_LEN) : io.log_len;
                io.overrun <= 1'b0;
                state      <= FLUSH;
                faddr      <= '0;
                sum        <= '0;
                wr_ptr     <= '0;
                cnt        <= '0;
                io.primed  <= 1'b0;
                io.busy    <= 1'b1;
            end else begin
                if (strobe && (state == READ || state == UPDATE || state == OUTPUT))
                    io.overrun <= 1'b1;
                case (state)
                    FLUSH: begin
                        faddr <= faddr + 1'b1;
                        if (faddr == '1) begin
                            state   <= IDLE;
                            io.busy <= 1'b0;
                        end
                    end
                    IDLE: if (strobe) begin
                        sample <= io.signal;
                        state  <= READ;
                    end
                    READ: begin
                        oldest <= mem[wr_ptr];
                        state  <= UPDATE;
                    end
                    UPDATE: begin
                        sum    <= sum + SW'(sample) - SW'(oldest);
                        wr_ptr <= (wr_ptr + 1'b1) & AW'(win - 1'b1);
                        cnt    <= (cnt == win) ? cnt : cnt + 1'b1;
                        state  <= OUTPUT;
                    end
                    OUTPUT: begin
                        io.filtered <= DATA_W'(sum >>> len_q);
                        io.valid    <= 1'b1;
                        io.primed   <= io.primed | (cnt == win);
                        state       <= IDLE;
                    end
                    default: state <= FLUSH;
                endcase
            end
        end
    end
endmodule

// File: doc/block_average_ctrl.md
# block_average_ctrl

Sequencing controller for a sliding-window block averager on the NCO-timed sample path. Derives a sample strobe from a selectable phase-accumulator bit, sequences a circular sample buffer and running sum through a fixed 3-cycle update, and handles runtime window-length and tap reconfiguration with a full buffer flush. Sits between the phase accumulator / waveform source and the output DAC formatter, replacing the free-running 64-term adder tree with a scheduled running-sum datapath.

## Interface
- DATA_W, 8, signed sample width
- MAX_LOG_LEN, 6, log2 of maximum window length (buffer depth 2^MAX_LOG_LEN)
- PHASE_W, 32, phase accumulator width
- clk  in  1  system clock; all logic on rising edge
- rst  in  1  synchronous, active-high reset
- phase  in  PHASE_W  current NCO phase
- signal  in  DATA_W  signed input sample
- cfg_load  in  1  one-cycle pulse: latch tap_sel/log_len and flush
- tap_sel  in  5  phase bit whose toggles (either edge) produce a sample strobe
- log_len  in  3  window length = 2^log_len; values > MAX_LOG_LEN clamp to MAX_LOG_LEN
- filtered  out  DATA_W  signed window average, registered
- valid  out  1  one-cycle pulse when filtered updates
- primed  out  1  window completely filled since last flush
- busy  out  1  flush in progress; strobes ignored
- overrun  out  1  sticky: strobe arrived while update in progress

## Operation
- Edge detect: prev_bit <= phase[tap_q] every cycle in every state; strobe = phase[tap_q] ^ prev_bit. signal captured into sample register on the strobe cycle.
- FSM states: FLUSH, IDLE, READ, UPDATE, OUTPUT.
- FLUSH: write 0 to buffer address 0..2^MAX_LOG_LEN-1, one per cycle (64 cycles default); sum=0, wr_ptr=0, fill count=0, primed=0; busy=1. Then IDLE.
- IDLE: on strobe -> READ.
- READ: read oldest entry buf[wr_ptr].
- UPDATE: sum <= sum + sample - oldest; buf[wr_ptr] <= sample; wr_ptr <= (wr_ptr+1) mod 2^len_q; count saturates at 2^len_q.
- OUTPUT: filtered <= (sum >>> len_q) truncated to DATA_W; valid=1; primed=1 once count == 2^len_q. -> IDLE.
- Arithmetic: sum signed, DATA_W+MAX_LOG_LEN bits (14); cannot overflow (range -8192..8128). Arithmetic right shift = floor toward -inf; no rounding. Before primed, empty slots count as zero (output ramps).
- Strobe in READ/UPDATE/OUTPUT: sample dropped, overrun<=1. overrun clears only on rst or cfg_load.
- cfg_load in any state: tap_q<=tap_sel, len_q<=clamp(log_len), overrun<=0, enter FLUSH at address 0 (restarts an in-progress flush). Same-cycle strobe is dropped without setting overrun. In-flight update abandoned; no valid.
- Strobes during FLUSH dropped, no overrun.

## Timing
- Reset values: filtered=0, valid=0, primed=0, overrun=0, busy=1 (state FLUSH), tap_q=27, len_q=6, prev_bit=0, sum=0, wr_ptr=0.
- Strobe detected at edge E0 -> READ at E1, UPDATE at E2, OUTPUT at E3; filtered/valid visible after E3 (latency 3 cycles). valid high exactly one cycle.
- Minimum strobe spacing without overrun: 4 cycles.
- Flush duration: 2^MAX_LOG_LEN cycles after rst deassert or cfg_load; busy falls the cycle state returns to IDLE.
- primed asserts with the valid of the 2^len_q-th sample after flush.

## Test plan
- Reset, hold 70 cycles, phase static -> busy high exactly 64 cycles, then 0; filtered=0, valid never pulses.
- cfg_load tap_sel=27 log_len=2, signal=40, toggle phase[27] every 10 cycles -> filtered 10,20,30,40,40; primed rises with 4th valid; valid 3 cycles after each toggle.
- log_len=2, signal=-3 constant -> filtered -1,-2,-3,-3 (floor shift).
- log_len=6, signal=127 then -128, 64 strobes each -> settles at 127 then -128; no wrap errors; log_len=7 behaves as 6.
- Two strobes 2 cycles apart -> second dropped, overrun=1 sticky across later clean strobes; cfg_load clears it.
- Mid-stream cfg_load log_len=0 simultaneous with strobe -> no valid, busy 64 cycles, overrun 0; next strobe with signal=-5 -> filtered=-5, primed=1.
